// File: rtl/if_ex_pipe_reg.sv
// Fetch-to-execute pipeline register with a 2-entry skid buffer and flush squash.
// Optional perf counters (flush_cnt, stall_cnt) are enabled by defining IF_EX_PERF_CNT_EN.
module if_ex_pipe_reg #(
  parameter int              XLEN     = 32,
  parameter logic [31:0]     NOP_INST = 32'h00000013,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_inst,
  input  logic            flush
`ifdef IF_EX_PERF_CNT_EN
  ,
  output logic [31:0]     flush_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  logic            main_valid_q, main_valid_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [31:0]     main_inst_q, main_inst_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_inst_q, skid_inst_d;
  logic            accept;
  logic            consume;

  // if_ready depends only on registered skid state, never on ex_ready.
  assign if_ready = ~skid_valid_q;
  assign accept   = if_valid & if_ready;
  assign consume  = main_valid_q & ex_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_inst_d  = main_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || consume) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_pc_d    = skid_pc_q;
        main_inst_d  = skid_inst_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_pc_d    = if_pc;
        main_inst_d  = if_inst;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = if_pc;
      skid_inst_d  = if_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= RESET_PC;
      main_inst_q  <= NOP_INST;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP_INST;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_inst_q  <= main_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

  assign ex_valid = main_valid_q;
  assign ex_pc    = main_pc_q;
  assign ex_inst  = main_valid_q ? main_inst_q : NOP_INST;

`ifdef IF_EX_PERF_CNT_EN
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    flush_cnt_d = flush ? flush_cnt_q + 32'd1 : flush_cnt_q;
    stall_cnt_d = (main_valid_q && !ex_ready) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_cnt = flush_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
